// File: rtl/axi_lite_reg_slave_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axi_lite_reg_slave_pkg                                  |
// | Brief    : Shared defaults and address decode for the AXI-Lite     |
// |            register slave.                                         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package axi_lite_reg_slave_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 32;
    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int ID_WIDTH_DEFAULT   = 4;
    localparam int NUM_REGS_DEFAULT   = 16;

    localparam logic [31:0] VERSION_DEFAULT = 32'h0001_0000;
    localparam logic [31:0] DECERR_DEFAULT  = 32'hDEAD_BEEF;

    // Decoded address: mapped flag plus word index (index is zero-extended).
    typedef struct packed {
        logic        mapped;
        logic [31:0] idx;
    } decode_t;

    // Byte-lane bits are dropped, the next idx_bits form the index, and any
    // set bit above the index field makes the address unmapped.
    function automatic decode_t addr_decode(input logic [63:0] addr,
                                            input int          addr_lsb,
                                            input int          idx_bits);
        decode_t     d;
        logic [63:0] idx_mask;
        idx_mask = (64'd1 << idx_bits) - 64'd1;
        d.idx    = 32'((addr >> addr_lsb) & idx_mask);
        d.mapped = ((addr >> (addr_lsb + idx_bits)) == 64'd0);
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axi_lite_regfile                                        |
// | Brief    : Word register file with read-only version register 0,   |
// |            one write port and one combinational read port.         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module axi_lite_regfile #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] VERSION    = '0,
    localparam int                   IDX_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [IDX_WIDTH-1:0]           widx,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [IDX_WIDTH-1:0]           ridx,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

    // Entry 0 is never written; register 0 is served from VERSION instead.
    logic [DATA_WIDTH-1:0] store [NUM_REGS];

    // Storage update: async clear, writes to index 0 are silently dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                store[i] <= '0;
            end
        end else if (we && (widx != '0)) begin
            store[widx] <= wdata;
        end
    end

    // Combinational read port with the register-0 read-only mux.
    always_comb begin
        rdata = store[ridx];
        if (ridx == '0) begin
            rdata = VERSION;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        if (i == 0) begin : g_ro
            assign regs_flat[0 +: DATA_WIDTH] = VERSION;
        end else begin : g_rw
            assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = store[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axi_lite_reg_slave                                      |
// | Brief    : AXI-Lite responder (AR/R with ID, AW/W/B) backed by a   |
// |            word-addressed register file.                           |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module axi_lite_reg_slave
    import axi_lite_reg_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
    parameter int                    DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int                    ID_WIDTH    = ID_WIDTH_DEFAULT,
    parameter int                    NUM_REGS    = NUM_REGS_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] VERSION     = DATA_WIDTH'(VERSION_DEFAULT),
    parameter logic [DATA_WIDTH-1:0] DECERR_DATA = DATA_WIDTH'(DECERR_DEFAULT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [ID_WIDTH-1:0]            arid,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [ID_WIDTH-1:0]            rid,
    output logic                           rvalid,
    input  logic                           rready,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic                           wvalid,
    output logic                           wready,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int IDX_WIDTH = $clog2(NUM_REGS);
    localparam int ADDR_LSB  = $clog2(DATA_WIDTH / 8);

    decode_t               rd_dec;
    decode_t               wr_dec;
    logic                  rd_hit;
    logic                  wr_hit;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [DATA_WIDTH-1:0] rf_rdata;

    logic                  ar_hs;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  commit;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] awaddr_hold;
    logic [DATA_WIDTH-1:0] wdata_hold;

    // The index range test is redundant with the decode mask but keeps the
    // full decoded index meaningful for any parameterisation.
    assign rd_dec = addr_decode(64'(araddr), ADDR_LSB, IDX_WIDTH);
    assign wr_dec = addr_decode(64'(awaddr_hold), ADDR_LSB, IDX_WIDTH);
    assign rd_hit = rd_dec.mapped & (rd_dec.idx < 32'(NUM_REGS));
    assign wr_hit = wr_dec.mapped & (wr_dec.idx < 32'(NUM_REGS));
    assign rd_idx = rd_dec.idx[IDX_WIDTH-1:0];
    assign wr_idx = wr_dec.idx[IDX_WIDTH-1:0];

    assign arready = rst & (~rvalid | rready);
    assign awready = rst & ~aw_held;
    assign wready  = rst & ~w_held;
    assign ar_hs   = arvalid & arready;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign commit  = aw_held & w_held & (~bvalid | bready);

    axi_lite_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .VERSION    (VERSION)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (commit & wr_hit),
        .widx      (wr_idx),
        .wdata     (wdata_hold),
        .ridx      (rd_idx),
        .rdata     (rf_rdata),
        .regs_flat (regs_o)
    );

    // Single-stage read channel: capture data and ID on AR, release on R.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rid    <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rid    <= arid;
            rdata  <= rd_hit ? rf_rdata : DECERR_DATA;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

    // AW/W one-deep holding registers; the held flag blocks new handshakes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            awaddr_hold <= '0;
            wdata_hold  <= '0;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
            end else if (aw_hs) begin
                aw_held     <= 1'b1;
                awaddr_hold <= awaddr;
            end
            if (commit) begin
                w_held <= 1'b0;
            end else if (w_hs) begin
                w_held     <= 1'b1;
                wdata_hold <= wdata;
            end
        end
    end

    // Write response: set on commit, which takes priority over a B handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bvalid <= 1'b0;
        end else if (commit) begin
            bvalid <= 1'b1;
        end else if (bready) begin
            bvalid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_axi_lite_reg_slave                                   |
// | Brief    : Scoreboard bench for the AXI-Lite register slave.       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_axi_lite_reg_slave;

    localparam int                  NR      = 16;
    localparam logic [31:0]         C_VER   = 32'h0001_0000;
    localparam logic [31:0]         C_DEC   = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
    } r_exp_t;

    logic          clk;
    logic          rst;
    logic [31:0]   araddr;
    logic [3:0]    arid;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [3:0]    rid;
    logic          rvalid;
    logic          rready;
    logic [31:0]   awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic          wvalid;
    logic          wready;
    logic          bvalid;
    logic          bready;
    logic [NR*32-1:0] regs_o;

    int            n_tests;
    int            n_fail;
    int            b_pending;
    r_exp_t        r_exp_q[$];
    logic [31:0]   model [NR];

    axi_lite_reg_slave dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arid    (arid),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rid     (rid),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wvalid  (wvalid),
        .wready  (wready),
        .bvalid  (bvalid),
        .bready  (bready),
        .regs_o  (regs_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NR*32-1:0] obs,
                         input logic [NR*32-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [3:0] idx;
        idx = a[5:2];
        if (a[31:6] != 26'd0) return C_DEC;
        if (idx == 4'd0) return C_VER;
        return model[idx];
    endfunction

    function automatic logic [NR*32-1:0] model_flat();
        logic [NR*32-1:0] f;
        f = '0;
        f[31:0] = C_VER;
        for (int i = 1; i < NR; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) model[i] = 32'd0;
    endtask

    // Response monitor: every R/B beat is matched against the scoreboard.
    always @(negedge clk) begin
        r_exp_t e;
        if (rst && rvalid && rready) begin
            if (r_exp_q.size() == 0) begin
                check("r_unexpected", 1, 0);
            end else begin
                e = r_exp_q.pop_front();
                check("rdata", rdata, e.data);
                check("rid", rid, e.id);
            end
        end
        if (rst && bvalid && bready) begin
            if (b_pending == 0) check("b_unexpected", 1, 0);
            else b_pending--;
        end
    end

    // Wait for ready (0=ar,1=aw,2=w) with a cycle bound; return after the edge.
    task automatic hs_wait(input int which, input string tag);
        int   n;
        logic rdy;
        n = 0;
        do begin
            @(negedge clk);
            rdy = (which == 0) ? arready : (which == 1) ? awready : wready;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) check({tag, "_timeout"}, 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id);
        r_exp_t e;
        e.id   = id;
        e.data = model_read(addr);
        r_exp_q.push_back(e);
        araddr  = addr;
        arid    = id;
        arvalid = 1'b1;
        hs_wait(0, "ar");
        arvalid = 1'b0;
        check("r_latency", rvalid, 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input int w_lead, input bit chk_lat);
        b_pending++;
        fork
            begin
                wdata  = data;
                wvalid = 1'b1;
                hs_wait(2, "w");
                wvalid = 1'b0;
                if (w_lead > 0) check("wready_drop", wready, 0);
            end
            begin
                if (w_lead > 0) begin
                    repeat (w_lead) @(posedge clk);
                    #1;
                    check("no_early_bvalid", bvalid, 0);
                    check("no_early_commit", regs_o, model_flat());
                end
                awaddr  = addr;
                awvalid = 1'b1;
                hs_wait(1, "aw");
                awvalid = 1'b0;
            end
        join
        if (addr[31:6] == 26'd0 && addr[5:2] != 4'd0) model[addr[5:2]] = data;
        if (chk_lat) begin
            check("b_lat0", bvalid, 0);
            @(posedge clk);
            #1;
            check("b_lat1", bvalid, 1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((r_exp_q.size() != 0 || b_pending != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("drain_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; b_pending = 0;
        model_clear();
        rst = 1'b0;
        araddr = '0; arid = '0; arvalid = 1'b0; rready = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_regs", regs_o, model_flat());
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Version register read with ID echo
        do_read(32'h0, 4'h3);
        drain();

        // AW and W together
        do_write(32'h8, 32'hCAFE_F00D, 0, 1);
        drain();
        do_read(32'h8, 4'h1);
        drain();
        check("regs_o_2", regs_o[2*32 +: 32], 32'hCAFE_F00D);

        // W three cycles ahead of AW
        do_write(32'h4, 32'h0000_1234, 3, 1);
        drain();
        do_read(32'h4, 4'h2);
        drain();

        // Register 0 write is dropped
        do_write(32'h0, 32'h1111_2222, 0, 1);
        drain();
        do_read(32'h0, 4'h7);
        drain();

        // Unmapped read and write
        do_read(32'h100, 4'h9);
        drain();
        do_write(32'h100, 32'h55, 0, 1);
        drain();
        check("unmapped_regs", regs_o, model_flat());

        // R back-pressure
        rready = 1'b0;
        do_read(32'h8, 4'h5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rbp_arready", arready, 0);
            check("rbp_rdata", rdata, 32'hCAFE_F00D);
            check("rbp_rid", rid, 4'h5);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        drain();

        // B back-pressure: second pair stays held
        bready = 1'b0;
        do_write(32'h14, 32'h0000_5151, 0, 0);
        do_write(32'h18, 32'h0000_6262, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bbp_awready", awready, 0);
            check("bbp_wready", wready, 0);
            check("bbp_bvalid", bvalid, 1);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(posedge clk); #1;
        check("bbp_bvalid_stays", bvalid, 1);
        drain();
        do_read(32'h18, 4'hA);
        drain();
        check("bbp_regs", regs_o, model_flat());

        // Reset mid-write
        do_write(32'hC, 32'h0000_AAAA, 0, 1);
        drain();
        do_write(32'h10, 32'h0000_0777, 0, 0);
        rst = 1'b0;
        b_pending = 0;
        model_clear();
        @(negedge clk);
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_awready", awready, 0);
        check("mid_rst_regs", regs_o, model_flat());
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_bvalid", bvalid, 0);
        end
        @(posedge clk); #1;
        do_read(32'hC, 4'hB);
        drain();
        do_read(32'h0, 4'hC);
        drain();
        check("post_rst_regs", regs_o, model_flat());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

Synthesizable AXI-Lite responder that terminates the master-side AXI-Lite channels (AR/R with ID, AW/W/B) and backs them with a small word-addressed register file. It is the DUT end of the AXI-Lite bench: the bench master drives it through the interface's slave-side signal directions. Register contents are exported for scoreboard and debug observation.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; a multiple of 8
- ID_WIDTH, 4, AR/R ID width
- NUM_REGS, 16, register count; a power of two, ≥2
- VERSION, 32'h0001_0000, read-only value of register 0
- DECERR_DATA, 32'hDEAD_BEEF, read data returned for unmapped addresses
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-low
- araddr  in  ADDR_WIDTH  read address
- arid  in  ID_WIDTH  read ID
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_WIDTH  read data
- rid  out  ID_WIDTH  read ID echo
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  ADDR_WIDTH  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DATA_WIDTH  write data
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- regs_o  out  NUM_REGS*DATA_WIDTH  register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Decode: ADDR_LSB = log2(DATA_WIDTH/8) and IDX = addr[ADDR_LSB +: log2(NUM_REGS)]. An address is mapped iff every bit above the index field is 0. The low ADDR_LSB bits are ignored.
- Register 0 always reads VERSION. Writes to register 0 are dropped but still get a B response. Registers 1..NUM_REGS-1 are read/write.
- Read path, single stage:
  - arready = rst & (~rvalid | rready).
  - A handshake (arvalid & arready) registers rvalid=1, rid=arid, and rdata = the mapped register value or DECERR_DATA.
  - rvalid clears on rvalid & rready unless a new AR handshake occurs on the same edge.
- Write path: AW and W are accepted independently, in either order, into one-deep holding registers with flags aw_held and w_held.
  - awready = rst & ~aw_held.
  - wready = rst & ~w_held.
- Write commit happens on any edge where aw_held & w_held & (~bvalid | bready). On that edge:
  - the mapped, writable register is updated; unmapped or register-0 writes are dropped;
  - bvalid is set;
  - both held flags are cleared.
- bvalid clears on bvalid & bready when no commit occurs on the same edge.
- Outputs hold stable while valid & ~ready.

## Timing
- Reset (rst=0) clears all registers 1..N-1, rvalid, rdata, rid, bvalid, aw_held and w_held. arready, awready and wready are 0 while reset is asserted.
- Read latency: AR handshake at edge T gives rvalid=1 after edge T. Back-to-back reads sustain one per cycle while rready=1.
- Write latency: the later of the AW/W handshakes at edge T gives commit and bvalid=1 after edge T+1.
- Sustained writes complete one every 2 cycles when bready is held at 1.
- Read/write collision: if the AR handshake and a commit to the same register happen on the same edge, the read returns the old value. A read whose handshake is at a later edge returns the new value.
- Back-pressure:
  - With bvalid=1 and bready=0, a new AW/W pair stays held and awready=wready=0.
  - When bready rises, the commit and the B handshake happen on the same edge, and bvalid stays 1.
- A reset asserted mid-transaction drops all pending AW, W, R and B state. There is no response after reset is released.

## Structure
- Package axi_lite_reg_slave_pkg holds:
  - the default widths;
  - VERSION_DEFAULT and DECERR_DEFAULT;
  - a function addr_decode(addr) that returns {mapped, idx}.
- One sub-module, axi_lite_regfile. It contains:
  - NUM_REGS storage;
  - the register-0 read-only mux;
  - one write port (we, widx, wdata);
  - one combinational read port (ridx, rdata).
- The top level keeps the handshake control.

## Test plan
- Reset, then read address 0x0 with arid=4'h3: rdata=32'h0001_0000, rid=4'h3, and rvalid one cycle after the handshake.
- AW 0x8 and W 0xCAFE_F00D in the same cycle, bready=1: bvalid after 2 cycles, then a read of 0x8 returns 0xCAFE_F00D and regs_o[2] matches.
- W issued 3 cycles before AW for address 0x4, data 0x1234: wready drops after its handshake, the write commits only after AW, and a read of 0x4 returns 0x1234.
- Read 0x100 (unmapped) returns 0xDEAD_BEEF. A write of 0x55 to 0x100 gets a B response, and all registers are unchanged.
- Hold rready=0 for 4 cycles with rvalid=1: arready=0, and rdata/rid are stable. Repeat with bready=0: the next AW/W pair is held with awready=wready=0.
- Write 0xAAAA to 0xC, then pulse rst low mid-way through a second write before B: after reset every register reads 0 except register 0, bvalid=0, and no stray response appears.
